register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
- Parametrised successor to the single-issue renamed register file of the out-of-order RISC-V core.
- Holds architectural values plus a busy bit and ROB tag per register.
- Serves ISSUE decode slots per cycle, each with two source reads and one destination rename.
- Accepts COMMIT ROB retirements per cycle, with intra-bundle dependency resolution and optional commit-to-read bypass.

Parameters:
- XLEN, 32: data width.
- NREG, 32: register count (power of two); index 0 is hard-wired zero.
- ROB_W, 4: ROB tag width.
- ISSUE, 2: decode slots per cycle.
- COMMIT, 2: commit slots per cycle.
- Localparam REG_W = $clog2(NREG).

Ports:
- in_clk  input  1  clock, rising edge
- in_rst_n  input  1  reset; one clock, asynchronous, active-low
- in_rdy  input  1  global enable; when 0, state holds
- in_flush_enable  input  1  misprediction flush
- in_decoder_write_enable  input  ISSUE  per-slot rename request
- in_decoder_rd  input  ISSUE*REG_W  per-slot destination
- in_decoder_rd_reorder  input  ISSUE*ROB_W  per-slot ROB tag
- in_decoder_rs  input  2*ISSUE*REG_W  source addresses; port 2i=rs, 2i+1=rt of slot i
- out_decoder_busy  output  2*ISSUE  per-port busy
- out_decoder_data  output  2*ISSUE*XLEN  per-port data
- out_decoder_reorder  output  2*ISSUE*ROB_W  per-port tag
- in_rob_commit_enable  input  COMMIT  per-slot commit valid
- in_rob_rd_addr  input  COMMIT*REG_W  commit destination
- in_rob_rd_value  input  COMMIT*XLEN  commit value
- in_rob_reorder  input  COMMIT*ROB_W  commit tag

Behaviour:
- Reset (async, in_rst_n=0): all data, busy and tag cleared to 0. Outputs are combinational from state, so they read busy=0, data=0, reorder=0 during reset. Reset mid-bundle discards all pending renames and commits.
- Read ports are combinational (zero latency). Per-port priority, highest first:
  - (a) Address 0: busy=0, data=0, reorder=0.
  - (b) Intra-bundle rename: if some slot j<i has write_enable, rd==address and rd!=0, then busy=1 and reorder = tag of the largest such j. Data is the stored value and is don't-care.
  - (c) Bypass (optional feature only): see Optional Feature.
  - (d) Stored busy, data and tag.
- A slot never observes its own rename.
- Sequential update happens on rising edge when in_rdy=1:
  - Commit data: every enabled commit slot with rd!=0 writes data. Same rd in several slots: the highest slot index wins.
  - Commit busy-clear: for register r, if any enabled commit slot targets r with tag == stored tag[r], then busy[r]=0 and tag[r]=0. The clear is suppressed if any decode slot renames r in the same cycle.
  - Rename: busy=1 and tag updated for each enabled slot with rd!=0. Same rd in several slots: the highest slot index wins. Rename overrides a commit clear on the same register.
  - Flush: all busy=0 and all tags=0. Commit data writes in the same cycle still occur (jalr link). Renames in the same cycle are ignored.
- in_rdy=0: no state change, outputs still track state.
- Register 0 is never written, never busy.
- Stale commit (tag mismatch) updates data only; busy and tag are untouched.

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- Defined: read priority (c) is active. If stored busy[a]=1 and an enabled commit slot has rd==a and tag == stored tag[a], the port returns busy=0 and data = that commit value (highest matching slot). Reorder is 0.
- Undefined: there is no bypass. The read returns stored busy=1, and the decoder relies on the ROB/CDB to supply the value.

Decomposition:
- Shared package/def file holds XLEN, ROB_W and NREG defaults, plus ZERO_DATA, ZERO_ROB, ZERO_REG, TRUE and FALSE.
- One sub-module, regfile_read_port: a purely combinational resolver for one port, taking the slot index as parameter and implementing the priority chain.
- Instantiate it 2*ISSUE times via generate.

Test Plan:
- Reset: drive in_rst_n low asynchronously mid-cycle after writes. Expect all ports to read busy=0, data=0, tag=0 immediately.
- Rename x5 tag 3 in slot 0, with slot 1 reading rs=x5 in the same cycle. Expect slot 1 port 2 busy=1, tag=3. Next cycle, a read of x5 returns busy=1, tag=3.
- With x5 busy tag 3, commit x5=0xDEAD tag 3. Next cycle expect busy=0, data=0xDEAD. A commit with tag 2 instead writes data but leaves busy=1, tag=3.
- Commit x5 tag 3 while slot 0 renames x5 tag 6 in the same cycle. Expect busy=1, tag=6, data=committed value.
- Flush with a simultaneous commit x1=0x100. Expect all busy cleared and x1=0x100. Any rename in that cycle is dropped.
- With REGFILE_COMMIT_BYPASS_EN: x7 busy tag 4, commit x7=0x55 tag 4, read x7 the same cycle. Expect busy=0, data=0x55. Without the macro, expect busy=1, tag=4.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared defaults and constants for the multi-port renamed register file.
// Optional commit-to-read bypass is enabled by defining REGFILE_COMMIT_BYPASS_EN.
package register_file_mp_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int ROB_W_DEF = 4;

    localparam logic [XLEN_DEF-1:0]          ZERO_DATA = '0;
    localparam logic [ROB_W_DEF-1:0]         ZERO_ROB  = '0;
    localparam logic [$clog2(NREG_DEF)-1:0]  ZERO_REG  = '0;
    localparam logic                         TRUE      = 1'b1;
    localparam logic                         FALSE     = 1'b0;

endpackage

// File: rtl/register_file_mp_read_port.sv
// Combinational resolver for one decoder read port: x0, older-slot rename,
// optional commit bypass (REGFILE_COMMIT_BYPASS_EN), then stored state.
module regfile_read_port
    import register_file_mp_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREG   = NREG_DEF,
    parameter  int ROB_W  = ROB_W_DEF,
    parameter  int ISSUE  = 2,
`ifdef REGFILE_COMMIT_BYPASS_EN
    parameter  int COMMIT = 2,
`endif
    parameter  int SLOT   = 0,
    localparam int REG_W  = $clog2(NREG)
) (
    input  logic [REG_W-1:0]        addr,
    input  logic                    stored_busy,
    input  logic [XLEN-1:0]         stored_data,
    input  logic [ROB_W-1:0]        stored_tag,
    input  logic [ISSUE-1:0]        dec_we,
    input  logic [ISSUE*REG_W-1:0]  dec_rd,
    input  logic [ISSUE*ROB_W-1:0]  dec_tag,
`ifdef REGFILE_COMMIT_BYPASS_EN
    input  logic [COMMIT-1:0]       commit_en,
    input  logic [COMMIT*REG_W-1:0] commit_rd,
    input  logic [COMMIT*XLEN-1:0]  commit_value,
    input  logic [COMMIT*ROB_W-1:0] commit_tag,
`endif
    output logic                    busy,
    output logic [XLEN-1:0]         data,
    output logic [ROB_W-1:0]        reorder
);

    logic             rename_hit;
    logic [ROB_W-1:0] rename_tag;
`ifdef REGFILE_COMMIT_BYPASS_EN
    logic             bypass_hit;
    logic [XLEN-1:0]  bypass_data;
`endif

    always_comb begin
        rename_hit = FALSE;
        rename_tag = ROB_W'(ZERO_ROB);
        // Ascending scan so the youngest older slot's tag is the one kept.
        for (int j = 0; j < ISSUE; j++) begin
            if (j < SLOT && dec_we[j] && dec_rd[j*REG_W +: REG_W] == addr) begin
                rename_hit = TRUE;
                rename_tag = dec_tag[j*ROB_W +: ROB_W];
            end
        end
`ifdef REGFILE_COMMIT_BYPASS_EN
        bypass_hit  = FALSE;
        bypass_data = XLEN'(ZERO_DATA);
        for (int c = 0; c < COMMIT; c++) begin
            if (stored_busy && commit_en[c] && commit_rd[c*REG_W +: REG_W] == addr &&
                commit_tag[c*ROB_W +: ROB_W] == stored_tag) begin
                bypass_hit  = TRUE;
                bypass_data = commit_value[c*XLEN +: XLEN];
            end
        end
`endif
        busy    = stored_busy;
        data    = stored_data;
        reorder = stored_tag;
        if (addr == REG_W'(ZERO_REG)) begin
            busy    = FALSE;
            data    = XLEN'(ZERO_DATA);
            reorder = ROB_W'(ZERO_ROB);
        end else if (rename_hit) begin
            busy    = TRUE;
            reorder = rename_tag;
        end
`ifdef REGFILE_COMMIT_BYPASS_EN
        else if (bypass_hit) begin
            busy    = FALSE;
            data    = bypass_data;
            reorder = ROB_W'(ZERO_ROB);
        end
`endif
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-issue / multi-commit renamed register file with busy bit and ROB tag.
// Define REGFILE_COMMIT_BYPASS_EN to forward matching commits to same-cycle reads.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREG   = NREG_DEF,
    parameter  int ROB_W  = ROB_W_DEF,
    parameter  int ISSUE  = 2,
    parameter  int COMMIT = 2,
    localparam int REG_W  = $clog2(NREG)
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic                      in_rdy,
    input  logic                      in_flush_enable,
    input  logic [ISSUE-1:0]          in_decoder_write_enable,
    input  logic [ISSUE*REG_W-1:0]    in_decoder_rd,
    input  logic [ISSUE*ROB_W-1:0]    in_decoder_rd_reorder,
    input  logic [2*ISSUE*REG_W-1:0]  in_decoder_rs,
    output logic [2*ISSUE-1:0]        out_decoder_busy,
    output logic [2*ISSUE*XLEN-1:0]   out_decoder_data,
    output logic [2*ISSUE*ROB_W-1:0]  out_decoder_reorder,
    input  logic [COMMIT-1:0]         in_rob_commit_enable,
    input  logic [COMMIT*REG_W-1:0]   in_rob_rd_addr,
    input  logic [COMMIT*XLEN-1:0]    in_rob_rd_value,
    input  logic [COMMIT*ROB_W-1:0]   in_rob_reorder
);

    logic [XLEN-1:0]  data_reg [NREG];
    logic [XLEN-1:0]  data_next [NREG];
    logic [ROB_W-1:0] tag_reg  [NREG];
    logic [ROB_W-1:0] tag_next [NREG];
    logic [NREG-1:0]  busy_reg;
    logic [NREG-1:0]  busy_next;

    always_comb begin
        data_next = data_reg;
        tag_next  = tag_reg;
        busy_next = busy_reg;
        // Ascending slot order makes the highest commit slot win on equal rd.
        for (int c = 0; c < COMMIT; c++) begin
            if (in_rob_commit_enable[c] && in_rob_rd_addr[c*REG_W +: REG_W] != REG_W'(ZERO_REG))
                data_next[in_rob_rd_addr[c*REG_W +: REG_W]] = in_rob_rd_value[c*XLEN +: XLEN];
        end
        // Busy clear compares against the stored tag; a stale commit leaves busy alone.
        for (int c = 0; c < COMMIT; c++) begin
            if (in_rob_commit_enable[c] && in_rob_rd_addr[c*REG_W +: REG_W] != REG_W'(ZERO_REG) &&
                in_rob_reorder[c*ROB_W +: ROB_W] == tag_reg[in_rob_rd_addr[c*REG_W +: REG_W]]) begin
                busy_next[in_rob_rd_addr[c*REG_W +: REG_W]] = FALSE;
                tag_next[in_rob_rd_addr[c*REG_W +: REG_W]]  = ROB_W'(ZERO_ROB);
            end
        end
        if (in_flush_enable) begin
            busy_next = '0;
            for (int r = 0; r < NREG; r++)
                tag_next[r] = ROB_W'(ZERO_ROB);
        end else begin
            // Renames come last so they override any same-cycle commit clear.
            for (int i = 0; i < ISSUE; i++) begin
                if (in_decoder_write_enable[i] && in_decoder_rd[i*REG_W +: REG_W] != REG_W'(ZERO_REG)) begin
                    busy_next[in_decoder_rd[i*REG_W +: REG_W]] = TRUE;
                    tag_next[in_decoder_rd[i*REG_W +: REG_W]]  = in_decoder_rd_reorder[i*ROB_W +: ROB_W];
                end
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            busy_reg <= '0;
            for (int r = 0; r < NREG; r++) begin
                data_reg[r] <= XLEN'(ZERO_DATA);
                tag_reg[r]  <= ROB_W'(ZERO_ROB);
            end
        end else if (in_rdy) begin
            busy_reg <= busy_next;
            data_reg <= data_next;
            tag_reg  <= tag_next;
        end
    end

    for (genvar gi = 0; gi < ISSUE; gi++) begin : g_slot
        for (genvar gk = 0; gk < 2; gk++) begin : g_port
            localparam int P = 2*gi + gk;
            logic [REG_W-1:0] addr;
            assign addr = in_decoder_rs[P*REG_W +: REG_W];

            regfile_read_port #(
                .XLEN   (XLEN),
                .NREG   (NREG),
                .ROB_W  (ROB_W),
                .ISSUE  (ISSUE),
`ifdef REGFILE_COMMIT_BYPASS_EN
                .COMMIT (COMMIT),
`endif
                .SLOT   (gi)
            ) u_read_port (
                .addr         (addr),
                .stored_busy  (busy_reg[addr]),
                .stored_data  (data_reg[addr]),
                .stored_tag   (tag_reg[addr]),
                .dec_we       (in_decoder_write_enable),
                .dec_rd       (in_decoder_rd),
                .dec_tag      (in_decoder_rd_reorder),
`ifdef REGFILE_COMMIT_BYPASS_EN
                .commit_en    (in_rob_commit_enable),
                .commit_rd    (in_rob_rd_addr),
                .commit_value (in_rob_rd_value),
                .commit_tag   (in_rob_reorder),
`endif
                .busy         (out_decoder_busy[P]),
                .data         (out_decoder_data[P*XLEN +: XLEN]),
                .reorder      (out_decoder_reorder[P*ROB_W +: ROB_W])
            );
        end
    end

endmodule
